fb_bank_scheduler: RTL
======================

FB_BANK_SCHEDULER -- requirements
Module: fb_bank_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 17: per-bank pixel address width.
REQ-002 SHALL have parameter FRAME_PIXELS, default 76800: pixels per 320x240 frame.
REQ-003 SHALL have parameter DROP_W, default 8: width of the drop counter.
REQ-004 SHALL have ports: pclk in 1, capture clock; reset in 1, asynchronous active-high reset.
REQ-005 SHALL have ports: v_sync in 1, camera vsync, high = blanking; cam_we in 1, cam_waddr in ADDR_W, cam_wdata in 16, RGB565 write from the capture path.
REQ-006 SHALL have ports: rd_frame_req in 1, level, display requests a new frame.
REQ-007 SHALL have ports: mem_we out 1, mem_waddr out ADDR_W+1 ({bank, addr}), mem_wdata out 16, to the dual-bank frame buffer.
REQ-008 SHALL have ports: wr_bank out 1, rd_bank out 1, rd_frame_ack out 1 (1-cycle pulse), frame_ready out 1, drop_cnt out DROP_W, frame_err out 1 (1-cycle pulse).

Function
REQ-009 SHALL implement FSM states WAIT_SYNC, WAIT_START, CAPTURE, COMMIT, with v_sync registered once (vs_q) for edge detection.
REQ-010 WAIT_SYNC SHALL go to WAIT_START when vs_q=1, discarding any partial frame after reset.
REQ-011 WAIT_START SHALL go to CAPTURE on the v_sync falling edge (vs_q=1, v_sync=0) and latch wr_bank = ~(next rd_bank).
REQ-012 CAPTURE SHALL go to COMMIT on the v_sync rising edge; COMMIT SHALL last exactly one cycle, then go to WAIT_START.
REQ-013 mem_we/mem_waddr/mem_wdata SHALL be registered, latency 1: mem_we = cam_we AND state==CAPTURE; mem_waddr = {wr_bank, cam_waddr}.
REQ-014 cam_waddr >= FRAME_PIXELS SHALL suppress mem_we for that cycle.
REQ-015 COMMIT SHALL set frame_ready=1 and mark wr_bank as the ready bank; if frame_ready was already 1, drop_cnt SHALL increment.
REQ-016 On entry to CAPTURE with frame_ready=1 and no grant that cycle, frame_ready SHALL clear and drop_cnt SHALL increment, because the ready bank is being overwritten.
REQ-017 Grant: rd_frame_req=1 AND registered frame_ready=1 SHALL, next cycle, set rd_bank = ready bank, clear frame_ready, and pulse rd_frame_ack.
REQ-018 rd_frame_req with frame_ready=0 SHALL hold rd_bank unchanged and produce no ack until a frame is ready.
REQ-019 Grant and COMMIT in the same cycle: COMMIT SHALL take effect and the grant SHALL resolve on the following cycle using the new frame.
REQ-020 Grant and CAPTURE entry in the same cycle: the grant SHALL win, no drop SHALL count, and wr_bank SHALL be the bank just released by the reader.
REQ-021 wr_bank and rd_bank SHALL never be equal while state==CAPTURE.
REQ-022 drop_cnt SHALL saturate at all-ones.

Reset
REQ-023 Reset SHALL force state=WAIT_SYNC, vs_q=0, rd_bank=0, wr_bank=1, frame_ready=0, drop_cnt=0, mem_we=0, mem_waddr=0, mem_wdata=0, rd_frame_ack=0, frame_err=0.
REQ-024 Reset asserted mid-CAPTURE SHALL abandon the frame; no COMMIT and no ready frame SHALL follow.

Configuration
REQ-025 With macro FB_FRAME_CHECK_EN defined, a write counter SHALL count accepted mem_we per frame (cleared at CAPTURE entry); COMMIT SHALL set frame_ready only if count==FRAME_PIXELS, otherwise frame_err SHALL pulse and frame_ready/drop_cnt SHALL be unchanged.
REQ-026 Without FB_FRAME_CHECK_EN, COMMIT SHALL be unconditional and frame_err SHALL be tied 0.

Structure
REQ-027 Package fb_pkg SHALL hold the FSM state enum, FRAME_W=320, FRAME_H=240, and FRAME_PIXELS.
REQ-028 Sub-module fb_vsync_edge SHALL provide the registered v_sync with rise/fall pulses; everything else SHALL be a single module.

Verification
REQ-029 Reset, v_sync 1->0, 76800 writes at addr 0..76799, v_sync 0->1 -> mem_waddr[17]=1 throughout, frame_ready=1 one cycle after COMMIT.
REQ-030 rd_frame_req=1 after the first frame -> rd_frame_ack pulse, rd_bank=1, frame_ready=0; next frame writes with mem_waddr[17]=0.
REQ-031 Three frames with rd_frame_req=0 -> drop_cnt=2, rd_bank=0, no ack.
REQ-032 cam_we at cam_waddr=76800 -> mem_we stays 0; with FB_FRAME_CHECK_EN and 76799 writes -> frame_err pulse, frame_ready=0.
REQ-033 rd_frame_req asserted on the exact cycle of the v_sync falling edge with frame_ready=1 -> ack issued, drop_cnt unchanged, wr_bank=~rd_bank.
REQ-034 Reset asserted at pixel 40000 of a frame -> all outputs at reset values, and the next full frame after a v_sync high period commits to bank 1.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared types and frame geometry for the dual-bank frame buffer
// scheduler. Holds the scheduler FSM state encoding and the 320x240 frame
// constants used as defaults by the RTL.
package fb_pkg;

  localparam int FRAME_W      = 320;
  localparam int FRAME_H      = 240;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

  // Capture-side frame state:
  //   WAIT_SYNC  - after reset, waiting for a blanking interval so a partial
  //                frame already in flight is never captured
  //   WAIT_START - blanking, waiting for the v_sync falling edge
  //   CAPTURE    - active video, pixels are written to wr_bank
  //   COMMIT     - single cycle that publishes the finished bank
  typedef enum logic [1:0] {
    WAIT_SYNC  = 2'd0,
    WAIT_START = 2'd1,
    CAPTURE    = 2'd2,
    COMMIT     = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fb_vsync_edge.sv
// fb_vsync_edge: registers the camera v_sync once and reports its edges.
// The edge pulses are combinational from the live input against the
// registered copy, so they are valid in the same cycle v_sync changes.
module fb_vsync_edge (
  input  logic pclk,
  input  logic reset,
  input  logic v_sync_i,
  output logic vs_q_o,
  output logic rise_o,
  output logic fall_o
);

  logic vs_q;

  // One-stage history of v_sync for edge detection.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= v_sync_i;
    end
  end

  assign vs_q_o = vs_q;
  assign rise_o = v_sync_i & ~vs_q;
  assign fall_o = vs_q & ~v_sync_i;

endmodule

// File: rtl/fb_bank_scheduler.sv
// fb_bank_scheduler: ping-pong bank scheduler between a camera capture path
// and a display reader. The capture side writes one bank while the reader
// owns the other; finished frames are published at COMMIT and handed over
// on reader request. Frames overwritten before being read count as drops.
//
// Optional feature macro: FB_FRAME_CHECK_EN
//   defined   - a frame is only published if exactly FRAME_PIXELS writes were
//               accepted; short/long frames pulse frame_err instead
//   undefined - every COMMIT publishes the frame, frame_err is constant 0
//
// Reader handshake (rd_frame_req / rd_frame_ack):
//   rd_frame_req is a level. A grant happens in any cycle where
//   rd_frame_req=1 and the registered frame_ready=1 (except the COMMIT cycle,
//   where the grant waits one cycle so it picks up the newly committed
//   frame). On the following clock rd_bank switches to the ready bank,
//   frame_ready clears and rd_frame_ack is high for exactly one cycle.
module fb_bank_scheduler
  import fb_pkg::*;
#(
  parameter int ADDR_W       = 17,
  parameter int FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
  parameter int DROP_W       = 8
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              v_sync,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_waddr,
  input  logic [15:0]       cam_wdata,
  input  logic              rd_frame_req,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_waddr,
  output logic [15:0]       mem_wdata,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              rd_frame_ack,
  output logic              frame_ready,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              frame_err,
  output fb_state_e         dbg_state
);

  localparam logic [31:0] PIX_LIMIT = 32'(FRAME_PIXELS);

  fb_state_e         state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic              wr_bank_q, wr_bank_d;
  logic              ready_bank_q, ready_bank_d;
  logic              frame_ready_q, frame_ready_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              ack_q, ack_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W:0]   mem_waddr_q, mem_waddr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;

  logic              vs_q, vs_rise, vs_fall;
  logic              grant, start, in_range, frame_ok;
  logic [DROP_W-1:0] drop_inc;

  fb_vsync_edge u_vsync_edge (
    .pclk     (pclk),
    .reset    (reset),
    .v_sync_i (v_sync),
    .vs_q_o   (vs_q),
    .rise_o   (vs_rise),
    .fall_o   (vs_fall)
  );

  // Helper terms shared by the FSM and the bank bookkeeping.
  assign in_range = (32'(cam_waddr) < PIX_LIMIT);
  assign start    = (state_q == WAIT_START) && vs_fall;
  assign grant    = rd_frame_req && frame_ready_q && (state_q != COMMIT);
  assign drop_inc = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 1'b1;

`ifdef FB_FRAME_CHECK_EN
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             err_q;

  // Accepted-write count for the current frame, saturating so an
  // overlong frame can never wrap back onto FRAME_PIXELS.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (start) begin
      wr_cnt_d = '0;
    end else if (mem_we_d && !(&wr_cnt_q)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  // Write counter and frame-error pulse registers.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      err_q    <= (state_q == COMMIT) && !frame_ok;
    end
  end

  assign frame_ok  = (32'(wr_cnt_q) == PIX_LIMIT);
  assign frame_err = err_q;
`else
  assign frame_ok  = 1'b1;
  assign frame_err = 1'b0;
`endif

  // Next-state and bank bookkeeping. Grant and COMMIT are exclusive by
  // construction of grant; grant is resolved before capture entry so a
  // same-cycle start writes into the bank the reader just released.
  always_comb begin
    state_d       = state_q;
    rd_bank_d     = rd_bank_q;
    wr_bank_d     = wr_bank_q;
    ready_bank_d  = ready_bank_q;
    frame_ready_d = frame_ready_q;
    drop_cnt_d    = drop_cnt_q;
    ack_d         = 1'b0;

    case (state_q)
      WAIT_SYNC:  if (vs_q)    state_d = WAIT_START;
      WAIT_START: if (vs_fall) state_d = CAPTURE;
      CAPTURE:    if (vs_rise) state_d = COMMIT;
      COMMIT:                  state_d = WAIT_START;
      default:                 state_d = WAIT_SYNC;
    endcase

    if (grant) begin
      rd_bank_d     = ready_bank_q;
      frame_ready_d = 1'b0;
      ack_d         = 1'b1;
    end

    // Capture entry: always write the bank the reader does not own. If an
    // unread frame sits in that bank it is about to be overwritten.
    if (start) begin
      wr_bank_d = ~rd_bank_d;
      if (frame_ready_q && !grant) begin
        frame_ready_d = 1'b0;
        drop_cnt_d    = drop_inc;
      end
    end

    // Publish the finished bank; an unread older frame is lost.
    if (state_q == COMMIT && frame_ok) begin
      ready_bank_d  = wr_bank_q;
      frame_ready_d = 1'b1;
      if (frame_ready_q) begin
        drop_cnt_d = drop_inc;
      end
    end
  end

  // Write path: one-cycle registered pass-through of accepted camera writes.
  always_comb begin
    mem_we_d    = cam_we && (state_q == CAPTURE) && in_range;
    mem_waddr_d = {wr_bank_q, cam_waddr};
    mem_wdata_d = cam_wdata;
  end

  // FSM state register.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Bank ownership, handshake and drop-count registers.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      rd_bank_q     <= 1'b0;
      wr_bank_q     <= 1'b1;
      ready_bank_q  <= 1'b1;
      frame_ready_q <= 1'b0;
      drop_cnt_q    <= '0;
      ack_q         <= 1'b0;
    end else begin
      rd_bank_q     <= rd_bank_d;
      wr_bank_q     <= wr_bank_d;
      ready_bank_q  <= ready_bank_d;
      frame_ready_q <= frame_ready_d;
      drop_cnt_q    <= drop_cnt_d;
      ack_q         <= ack_d;
    end
  end

  // Frame-buffer write port registers.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wr_bank      = wr_bank_q;
  assign rd_bank      = rd_bank_q;
  assign rd_frame_ack = ack_q;
  assign frame_ready  = frame_ready_q;
  assign drop_cnt     = drop_cnt_q;
  assign dbg_state    = state_q;

endmodule
